decode_queue_unit: RTL and testbench

Registered, parametrised successor to the combinational RV32I instruction decoder. It accepts a full 32-bit instruction with a valid/ready handshake and decodes it. The decoded control bundle, including register indices and an illegal-instruction flag, goes into a DEPTH-entry FIFO. The block sits between instruction fetch and the register-file/execute stage, decoupling the two with back-pressure and flush support.

---
 rtl/decode_queue_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_decode_queue_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue_unit.sv
// decode_queue_unit: RV32I instruction decoder feeding a DEPTH-entry FIFO.
// Decoded bundles are stored and presented from the read pointer. A flush
// drops all queued entries. A saturating counter tracks illegal instructions
// that have been enqueued.
// Optional feature macro: DECODE_RV32M_EN. When it is defined, the OP
// encodings with funct7 = 0000001 (multiply/divide) are legal, and the
// muldiv_o output is added.
module decode_queue_unit #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       pc_in,
  input  logic              in_valid_in,
  output logic              in_ready_o,
  input  logic              flush_in,
  output logic              out_valid_o,
  input  logic              out_ready_in,
  output logic [31:0]       pc_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        rd_o,
  output logic [3:0]        alu_opcode_o,
  output logic [2:0]        wb_mux_sel_o,
  output logic [2:0]        imm_type_o,
  output logic [1:0]        load_size_o,
  output logic              load_unsigned_o,
  output logic              mem_wr_req_o,
  output logic              alu_src_o,
  output logic              iadder_src_o,
  output logic              wr_en_o,
  output logic              illegal_o,
`ifdef DECODE_RV32M_EN
  output logic              muldiv_o,
`endif
  output logic [CNT_W-1:0]  illegal_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [2:0]  wb_sel;
    logic [2:0]  imm_type;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic        mem_wr;
    logic        alu_src;
    logic        iadder_src;
    logic        wr_en;
    logic        illegal;
`ifdef DECODE_RV32M_EN
    logic        muldiv;
`endif
  } entry_t;

  entry_t      dec;
  entry_t      mem [DEPTH];
  entry_t      head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] illegal_cnt;
  logic        full, empty, push, pop;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];

  // Combinational decode of the incoming instruction into a bundle
  always_comb begin
    dec               = '0;
    dec.pc            = pc_in;
    dec.rs1           = instr_in[19:15];
    dec.rs2           = instr_in[24:20];
    dec.rd            = instr_in[11:7];
    dec.alu_op        = {1'b0, funct3};
    dec.load_size     = funct3[1:0];
    dec.load_unsigned = funct3[2];
    dec.alu_src       = instr_in[5];
    unique case (opcode)
      OPC_LOAD: begin
        dec.wb_sel     = 3'b001;
        dec.imm_type   = 3'b001;
        dec.iadder_src = 1'b1;
        dec.wr_en      = 1'b1;
        dec.illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_OP_IMM: begin
        dec.imm_type = 3'b001;
        dec.wr_en    = 1'b1;
        if (funct3 == 3'b101) begin
          dec.alu_op[3] = instr_in[30];
          dec.illegal   = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end else if (funct3 == 3'b001) begin
          dec.illegal = (funct7 != 7'b0000000);
        end
      end
      OPC_AUIPC: begin
        dec.wb_sel   = 3'b011;
        dec.imm_type = 3'b100;
        dec.wr_en    = 1'b1;
      end
      OPC_STORE: begin
        dec.imm_type   = 3'b010;
        dec.mem_wr     = 1'b1;
        dec.iadder_src = 1'b1;
        dec.illegal    = (funct3 > 3'b010);
      end
      OPC_OP: begin
        dec.wr_en     = 1'b1;
        dec.alu_op[3] = instr_in[30];
        if (funct7 == 7'b0000000) begin
          dec.illegal = 1'b0;
        end else if (funct7 == 7'b0100000) begin
          dec.illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
`ifdef DECODE_RV32M_EN
        end else if (funct7 == 7'b0000001) begin
          dec.muldiv = 1'b1;
          dec.alu_op = {1'b0, funct3};
`endif
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.wb_sel   = 3'b010;
        dec.imm_type = 3'b100;
        dec.wr_en    = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm_type = 3'b011;
        dec.illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_JALR: begin
        dec.wb_sel     = 3'b100;
        dec.imm_type   = 3'b001;
        dec.iadder_src = 1'b1;
        dec.wr_en      = 1'b1;
        dec.illegal    = (funct3 != 3'b000);
      end
      OPC_JAL: begin
        dec.wb_sel   = 3'b100;
        dec.imm_type = 3'b101;
        dec.wr_en    = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal entries must never write the register file or memory
    if (dec.illegal) begin
      dec.wr_en  = 1'b0;
      dec.mem_wr = 1'b0;
`ifdef DECODE_RV32M_EN
      dec.muldiv = 1'b0;
`endif
    end
  end

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign push        = in_valid_in && in_ready_o && !flush_in;
  assign pop         = out_valid_o && out_ready_in && !flush_in;

  // Pointer update; flush empties the queue and wins over push/pop
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage, cleared on reset so that no stale bundle is visible
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= dec;
    end
  end

  // Saturating illegal counter; flush leaves it untouched
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      illegal_cnt <= '0;
    end else if (push && dec.illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + CNT_ONE;
    end
  end

  assign head            = mem[rd_ptr[AW-1:0]];
  assign pc_o            = head.pc;
  assign rs1_o           = head.rs1;
  assign rs2_o           = head.rs2;
  assign rd_o            = head.rd;
  assign alu_opcode_o    = head.alu_op;
  assign wb_mux_sel_o    = head.wb_sel;
  assign imm_type_o      = head.imm_type;
  assign load_size_o     = head.load_size;
  assign load_unsigned_o = head.load_unsigned;
  assign mem_wr_req_o    = head.mem_wr;
  assign alu_src_o       = head.alu_src;
  assign iadder_src_o    = head.iadder_src;
  assign wr_en_o         = head.wr_en;
  assign illegal_o       = head.illegal;
`ifdef DECODE_RV32M_EN
  assign muldiv_o        = head.muldiv;
`endif
  assign illegal_cnt_o   = illegal_cnt;

endmodule

// File: tb/tb_decode_queue_unit.sv
// Bench for decode_queue_unit: an instruction table with hand-derived expected
// decode, and a scoreboard queue filled on accepted pushes and drained on pops.
// The illegal-instruction counter uses a narrow width so that saturation can be
// reached.
module tb_decode_queue_unit;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 3;
  localparam int NROWS   = 19;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic [31:0]       instr_in, pc_in;
  logic              in_valid_in, in_ready_o, flush_in;
  logic              out_valid_o, out_ready_in;
  logic [31:0]       pc_o;
  logic [4:0]        rs1_o, rs2_o, rd_o;
  logic [3:0]        alu_opcode_o;
  logic [2:0]        wb_mux_sel_o, imm_type_o;
  logic [1:0]        load_size_o;
  logic              load_unsigned_o, mem_wr_req_o, alu_src_o, iadder_src_o;
  logic              wr_en_o, illegal_o;
  logic [CNT_W-1:0]  illegal_cnt_o;
`ifdef DECODE_RV32M_EN
  logic              muldiv_o;
`endif

  decode_queue_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .instr_in(instr_in), .pc_in(pc_in),
    .in_valid_in(in_valid_in), .in_ready_o(in_ready_o), .flush_in(flush_in),
    .out_valid_o(out_valid_o), .out_ready_in(out_ready_in), .pc_o(pc_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .alu_opcode_o(alu_opcode_o),
    .wb_mux_sel_o(wb_mux_sel_o), .imm_type_o(imm_type_o),
    .load_size_o(load_size_o), .load_unsigned_o(load_unsigned_o),
    .mem_wr_req_o(mem_wr_req_o), .alu_src_o(alu_src_o),
    .iadder_src_o(iadder_src_o), .wr_en_o(wr_en_o), .illegal_o(illegal_o),
`ifdef DECODE_RV32M_EN
    .muldiv_o(muldiv_o),
`endif
    .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic [3:0]  alu;
    logic [2:0]  wb;
    logic [2:0]  imm;
    logic        we;
    logic        mw;
  } row_t;

  typedef struct {
    int          r;
    logic [31:0] pc;
  } exp_t;

  row_t        rows [NROWS];
  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;
  int          exp_cnt = 0;
  logic [31:0] pc_next = 32'h0000_1000;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic row_t mk(input logic [31:0] i, input logic ill, input logic [3:0] a,
                              input logic [2:0] w, input logic [2:0] im,
                              input logic we, input logic mw);
    row_t t;
    t.instr = i; t.ill = ill; t.alu = a; t.wb = w; t.imm = im; t.we = we; t.mw = mw;
    return t;
  endfunction

  // Called just after a falling edge: drive, predict handshakes, advance a cycle
  task automatic step(input logic v, input int r, input logic ordy, input logic fl,
                      output logic acc);
    exp_t e;
    row_t w;
    in_valid_in  = v;
    instr_in     = rows[r].instr;
    pc_in        = pc_next;
    out_ready_in = ordy;
    flush_in     = fl;
    #1;
    if (out_valid_o && ordy && !fl) begin
      if (sb.size() == 0) begin
        chk("spurious_pop", {31'd0, out_valid_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        w = rows[e.r];
        chk($sformatf("pc[%0d]", e.r), pc_o, e.pc);
        chk($sformatf("illegal[%0d]", e.r), {31'd0, illegal_o}, {31'd0, w.ill});
        chk($sformatf("wr_en[%0d]", e.r), {31'd0, wr_en_o}, {31'd0, w.we});
        chk($sformatf("mem_wr[%0d]", e.r), {31'd0, mem_wr_req_o}, {31'd0, w.mw});
        if (!w.ill) begin
          chk($sformatf("rd[%0d]", e.r), {27'd0, rd_o}, {27'd0, w.instr[11:7]});
          chk($sformatf("rs1[%0d]", e.r), {27'd0, rs1_o}, {27'd0, w.instr[19:15]});
          chk($sformatf("rs2[%0d]", e.r), {27'd0, rs2_o}, {27'd0, w.instr[24:20]});
          chk($sformatf("alu[%0d]", e.r), {28'd0, alu_opcode_o}, {28'd0, w.alu});
          chk($sformatf("wb[%0d]", e.r), {29'd0, wb_mux_sel_o}, {29'd0, w.wb});
          chk($sformatf("imm[%0d]", e.r), {29'd0, imm_type_o}, {29'd0, w.imm});
        end
      end
    end
    if (fl) sb.delete();
    acc = v && in_ready_o && !fl;
    if (acc) begin
      sb.push_back('{r, pc_next});
      pc_next = pc_next + 32'd4;
      if (rows[r].ill && exp_cnt < CNT_MAX) exp_cnt++;
    end
    @(negedge clk_in);
  endtask

  task automatic send(input int r, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) step(1'b1, r, ordy, 1'b0, acc);
    chk($sformatf("accept[%0d]", r), {31'd0, acc}, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 20 && sb.size() != 0; k++) step(1'b0, 0, 1'b1, 1'b0, acc);
    chk("drain_sb", sb.size(), 32'd0);
    chk("drain_valid", {31'd0, out_valid_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    rows[0]  = mk(32'h00500093, 0, 4'b0000, 3'b000, 3'b001, 1, 0); // addi
    rows[1]  = mk(32'h40B50533, 0, 4'b1000, 3'b000, 3'b000, 1, 0); // sub
    rows[2]  = mk(32'h4015D593, 0, 4'b1101, 3'b000, 3'b001, 1, 0); // srai
    rows[3]  = mk(32'h0000A023, 0, 4'b0010, 3'b000, 3'b010, 0, 1); // sw
    rows[4]  = mk(32'h123450B7, 0, 4'b0101, 3'b010, 3'b100, 1, 0); // lui
    rows[5]  = mk(32'h00000117, 0, 4'b0000, 3'b011, 3'b100, 1, 0); // auipc
    rows[6]  = mk(32'h008000EF, 0, 4'b0000, 3'b100, 3'b101, 1, 0); // jal
    rows[7]  = mk(32'h000080E7, 0, 4'b0000, 3'b100, 3'b001, 1, 0); // jalr
    rows[8]  = mk(32'h00208463, 0, 4'b0000, 3'b000, 3'b011, 0, 0); // beq
    rows[9]  = mk(32'h0000A103, 0, 4'b0010, 3'b001, 3'b001, 1, 0); // lw
    rows[10] = mk(32'h00B50533, 0, 4'b0000, 3'b000, 3'b000, 1, 0); // add
    rows[11] = mk(32'h40B55533, 0, 4'b1101, 3'b000, 3'b000, 1, 0); // sra
    rows[12] = mk(32'hFFFFFFFF, 1, 4'b0000, 3'b000, 3'b000, 0, 0); // bad opcode
    rows[13] = mk(32'h00003003, 1, 4'b0000, 3'b000, 3'b000, 0, 0); // load f3=011
    rows[14] = mk(32'h40B51533, 1, 4'b0000, 3'b000, 3'b000, 0, 0); // OP f7=20 f3=001
    rows[15] = mk(32'h0000B023, 1, 4'b0000, 3'b000, 3'b000, 0, 0); // store f3=011
    rows[16] = mk(32'h000090E7, 1, 4'b0000, 3'b000, 3'b000, 0, 0); // jalr f3=001
    rows[17] = mk(32'h1015D593, 1, 4'b0000, 3'b000, 3'b000, 0, 0); // shift-imm bad f7
    rows[18] = mk(32'h0020A463, 1, 4'b0000, 3'b000, 3'b000, 0, 0); // branch f3=010

    rst_n_in = 1'b0; in_valid_in = 1'b0; instr_in = '0; pc_in = '0;
    out_ready_in = 1'b0; flush_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    chk("rst_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_cnt", {29'd0, illegal_cnt_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);

    // single-cycle latency into an empty queue, then a back-to-back stream
    step(1'b1, 0, 1'b1, 1'b0, acc);
    chk("latency_valid", {31'd0, out_valid_o}, 32'd1);
    for (int r = 1; r < 12; r++) send(r, 1'b1);
    drain();

    // back-pressure: fill, then release with input held
    send(1, 1'b0);
    send(2, 1'b0);
    chk("full_ready", {31'd0, in_ready_o}, 32'd0);
    chk("full_valid", {31'd0, out_valid_o}, 32'd1);
    send(3, 1'b1);
    send(4, 1'b1);
    send(5, 1'b1);
    drain();

    // illegal instructions and counter
    send(12, 1'b1);
    send(13, 1'b1);
    drain();
    chk("cnt_two", {29'd0, illegal_cnt_o}, 32'd2);
    for (int r = 14; r < NROWS; r++) send(r, 1'b1);
    drain();
    chk("cnt_seven", {29'd0, illegal_cnt_o}, exp_cnt);
    send(12, 1'b1);
    drain();
    chk("cnt_sat", {29'd0, illegal_cnt_o}, 32'd7);

    // flush with a simultaneous push
    send(0, 1'b0);
    send(1, 1'b0);
    step(1'b1, 10, 1'b0, 1'b1, acc);
    chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
    chk("flush_ready", {31'd0, in_ready_o}, 32'd1);
    chk("flush_cnt", {29'd0, illegal_cnt_o}, exp_cnt);
    send(11, 1'b1);
    drain();

    // random traffic with stalls and occasional flushes
    for (int n = 0; n < 400; n++)
      step(1'(($urandom % 4) != 0), int'($urandom_range(0, NROWS - 1)),
           1'($urandom % 2), 1'(($urandom % 16) == 0), acc);
    drain();
    chk("rand_cnt", {29'd0, illegal_cnt_o}, exp_cnt);

    // reset in the middle of activity
    send(4, 1'b0);
    send(5, 1'b0);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready_o}, 32'd1);
    chk("midrst_cnt", {29'd0, illegal_cnt_o}, 32'd0);
    sb.delete();
    exp_cnt = 0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    send(6, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
